// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, FSM state encoding and queue entry type for
//               the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VECTOR = 64'h0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_SPACE = 2'd2,
        DRAIN      = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module      : fetch_buffer
// Description : 2-entry FIFO of {pc, inst}; slot 0 is always the head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_head_valid,
    output fetch_entry_t o_head_entry,
    output logic [1:0]   o_count
);

    fetch_entry_t [1:0] slot_q, slot_d;
    logic [1:0]         count_q, count_d;
    logic               w_pop;
    logic               w_push;
    logic [1:0]         w_wr_idx;

    always_comb begin
        slot_d   = slot_q;
        count_d  = count_q;
        w_pop    = i_pop && (count_q != 2'd0);
        w_wr_idx = count_q - {1'b0, w_pop};
        w_push   = i_push && (w_wr_idx < 2'd2);
        if (i_flush) begin
            count_d = 2'd0;
        end else begin
            // Shift on pop first so a same-cycle push lands behind the survivor.
            if (w_pop) begin
                slot_d[0] = slot_q[1];
            end
            if (w_push) begin
                slot_d[w_wr_idx[0]] = i_push_entry;
            end
            count_d = w_wr_idx + {1'b0, w_push};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            count_q <= 2'd0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign o_head_valid = (count_q != 2'd0);
    assign o_head_entry = slot_q[0];
    assign o_count      = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Fetch-stage sequencer: owns the PC, issues one-outstanding
//               imem requests and queues returned instructions for decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller #(
    parameter int              XLEN         = fetch_pkg::XLEN,
    parameter int              ILEN         = fetch_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    import fetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            imem_req_q, imem_req_d;

    logic [XLEN-1:0] w_redirect_target;
    logic            w_push;
    logic            w_pop;
    logic            w_head_valid;
    logic [1:0]      w_count;
    logic [1:0]      w_occ_after_ack;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign pc_next           = pc_q + XLEN'(INST_BYTES);
    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_pop             = w_head_valid && inst_ready;
    assign w_occ_after_ack   = w_count + 2'd1 - {1'b0, w_pop};
    assign w_push_entry.pc   = pc_q;
    assign w_push_entry.inst = imem_rdata;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        w_push   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d = w_redirect_target;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_d    = w_redirect_target;
                        state_d = REQ;
                    end else begin
                        w_push  = 1'b1;
                        pc_d    = pc_next;
                        state_d = (w_occ_after_ack < 2'd2) ? REQ : WAIT_SPACE;
                    end
                end else if (redirect_valid) begin
                    // The bus request cannot be withdrawn; wait for its ack.
                    target_d = w_redirect_target;
                    state_d  = DRAIN;
                end
            end
            WAIT_SPACE: begin
                if (redirect_valid) begin
                    pc_d    = w_redirect_target;
                    state_d = REQ;
                end else if ((w_count - {1'b0, w_pop}) < 2'd2) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    pc_d    = redirect_valid ? w_redirect_target : target_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    target_d = w_redirect_target;
                end
            end
            default: state_d = IDLE;
        endcase
        imem_req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            target_q   <= '0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            imem_req_q <= imem_req_d;
        end
    end

    fetch_buffer u_buffer (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (inst_ready),
        .i_flush      (redirect_valid),
        .o_head_valid (w_head_valid),
        .o_head_entry (w_head),
        .o_count      (w_count)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_valid = w_head_valid;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module      : tb_fetch_controller
// Description : Scoreboard bench for fetch_controller (request addresses and
//               delivered instructions checked by an independent monitor).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] pc;
    logic [63:0] pc_next;

    assign imem_rdata = imem_addr[31:0];

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc             (pc),
        .pc_next        (pc_next)
    );

    // Second instance exercising the PC wrap from a top-of-memory reset vector.
    logic        rst_w;
    logic        w_req;
    logic [63:0] w_addr;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [63:0] w_inst_pc;
    logic [63:0] w_pc;
    logic [63:0] w_pc_next;

    fetch_controller #(.RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk            (clk),
        .reset          (rst_w),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (1'b1),
        .imem_rdata     (w_addr[31:0]),
        .inst_valid     (w_valid),
        .inst_ready     (1'b1),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc),
        .pc             (w_pc),
        .pc_next        (w_pc_next)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_addr[$];
    logic [95:0] exp_inst[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the address of an acked request and, if it survives, its delivery.
    task automatic expect_fetch(input logic [63:0] a, input logic delivered);
        exp_addr.push_back(a);
        if (delivered) exp_inst.push_back({a, a[31:0]});
    endtask

    always @(negedge clk) begin : monitor
        logic [95:0] e;
        if (imem_req && imem_ack) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected: got addr %h want no ack", imem_addr);
            end else begin
                chk("req_addr", imem_addr, exp_addr.pop_front());
            end
        end
        if (inst_valid && inst_ready) begin
            if (exp_inst.size() == 0) begin
                total++;
                bad++;
                $display("FAIL inst_unexpected: got pc %h want none", inst_pc);
            end else begin
                e = exp_inst.pop_front();
                chk("inst_pc", inst_pc, e[95:32]);
                chk("inst", {32'h0, inst}, {32'h0, e[31:0]});
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        step();
        step();
        chk("left_addr", 64'(exp_addr.size()), 64'h0);
        chk("left_inst", 64'(exp_inst.size()), 64'h0);
        exp_addr.delete();
        exp_inst.delete();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rst_w = 1'b1;
        imem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 64'h0;
        step();
        @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_pc_next", pc_next, 64'h4);
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);

        // Streaming: one fetch per cycle, delivery one cycle behind.
        do_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        chk("t1_idle_req", {63'h0, imem_req}, 64'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            expect_fetch(64'(4 * i), 1'b1);
            @(negedge clk);
            chk("t1_valid", {63'h0, inst_valid}, (i > 0) ? 64'h1 : 64'h0);
            step();
        end
        imem_ack = 1'b0;
        @(negedge clk);
        chk("t1_pc", pc, 64'd24);
        chk("t1_req_hold", {63'h0, imem_req}, 64'h1);
        step(); step();

        // Backpressure: queue fills at two entries, request drops at pc 8.
        do_reset();
        imem_ack = 1'b1;
        step(); expect_fetch(64'h0, 1'b1);
        step(); expect_fetch(64'h4, 1'b1);
        step();
        @(negedge clk);
        chk("t2_req_off", {63'h0, imem_req}, 64'h0);
        chk("t2_pc", pc, 64'h8);
        chk("t2_head", inst_pc, 64'h0);
        step();
        @(negedge clk);
        chk("t2_head_stable", inst_pc, 64'h0);
        step(); inst_ready = 1'b1;
        @(negedge clk);
        chk("t2_req_still_off", {63'h0, imem_req}, 64'h0);
        step(); inst_ready = 1'b0; expect_fetch(64'h8, 1'b1);
        @(negedge clk);
        chk("t2_req_resume", {63'h0, imem_req}, 64'h1);
        chk("t2_addr_resume", imem_addr, 64'h8);
        step();
        @(negedge clk);
        chk("t2_full_again", {63'h0, imem_req}, 64'h0);
        step(); imem_ack = 1'b0; inst_ready = 1'b1;
        step(); step();

        // Redirect during a 3-cycle memory latency.
        do_reset();
        inst_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t3_addr0", imem_addr, 64'h0);
        step(); redirect_valid = 1'b1; redirect_pc = 64'h103;
        step(); redirect_valid = 1'b0; imem_ack = 1'b1; expect_fetch(64'h0, 1'b0);
        @(negedge clk);
        chk("t3_drain_req", {63'h0, imem_req}, 64'h1);
        chk("t3_drain_addr", imem_addr, 64'h0);
        chk("t3_drain_valid", {63'h0, inst_valid}, 64'h0);
        step(); imem_ack = 1'b0;
        @(negedge clk);
        chk("t3_new_addr", imem_addr, 64'h100);
        chk("t3_valid_a", {63'h0, inst_valid}, 64'h0);
        step();
        @(negedge clk);
        chk("t3_valid_b", {63'h0, inst_valid}, 64'h0);
        step(); imem_ack = 1'b1; expect_fetch(64'h100, 1'b1);
        @(negedge clk);
        chk("t3_valid_c", {63'h0, inst_valid}, 64'h0);
        step(); imem_ack = 1'b0;
        @(negedge clk);
        chk("t3_valid_d", {63'h0, inst_valid}, 64'h1);
        step();

        // Redirect coinciding with an ack while one entry is held.
        do_reset();
        imem_ack = 1'b1;
        step(); expect_fetch(64'h0, 1'b0);
        step(); redirect_valid = 1'b1; redirect_pc = 64'h202; expect_fetch(64'h4, 1'b0);
        @(negedge clk);
        chk("t4_occ1", {63'h0, inst_valid}, 64'h1);
        step(); redirect_valid = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        chk("t4_flushed", {63'h0, inst_valid}, 64'h0);
        chk("t4_addr", imem_addr, 64'h200);
        chk("t4_req", {63'h0, imem_req}, 64'h1);
        chk("t4_pc_next", pc_next, 64'h204);
        step(); inst_ready = 1'b1;
        step(); step();

        // PC wrap from the top reset vector.
        rst_w = 1'b0;
        @(negedge clk);
        chk("t5_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc_next", w_pc_next, 64'h0);
        chk("t5_idle_req", {63'h0, w_req}, 64'h0);
        step();
        @(negedge clk);
        chk("t5_addr1", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc_next1", w_pc_next, 64'h0);
        step();
        @(negedge clk);
        chk("t5_addr2", w_addr, 64'h0);
        chk("t5_head_pc", w_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_head_inst", {32'h0, w_inst}, 64'hFFFF_FFFC);
        step(); rst_w = 1'b1;

        // Reset asserted while draining; a later ack must be ignored.
        do_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        step(); expect_fetch(64'h0, 1'b1);
        step(); expect_fetch(64'h4, 1'b0);
        step(); imem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_drain_addr", imem_addr, 64'h8);
        chk("t6_drain_req", {63'h0, imem_req}, 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_req", {63'h0, imem_req}, 64'h0);
        chk("t6_rst_pc", pc, 64'h0);
        chk("t6_rst_inst_pc", inst_pc, 64'h0);
        chk("t6_rst_inst", {32'h0, inst}, 64'h0);
        chk("t6_rst_valid", {63'h0, inst_valid}, 64'h0);
        step(); imem_ack = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk);
        chk("t6_idle_req", {63'h0, imem_req}, 64'h0);
        chk("t6_idle_valid", {63'h0, inst_valid}, 64'h0);
        step(); expect_fetch(64'h0, 1'b1);
        @(negedge clk);
        chk("t6_first_addr", imem_addr, 64'h0);
        step(); imem_ack = 1'b0; inst_ready = 1'b1;
        step(); step();
        chk("end_left_addr", 64'(exp_addr.size()), 64'h0);
        chk("end_left_inst", 64'(exp_inst.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
